axi_burst_master: RTL and testbench
===================================

// Module: axi_burst_master
// PURPOSE
//  Parametrised AXI4 master port for the L1 caches: single-word or cache-line (INCR burst) reads/writes.
//  Sits between an L1C controller and one AXI master port of the bus; one instance per cache.
//  Adds burst line fill/writeback, RLAST/RRESP/BRESP checking and a per-transaction watchdog timeout.
// PARAMETERS
//  ADDR_W      32    address width (bits)
//  DATA_W      32    data width; power of 2, >=32
//  ID_W        4     AXI ID width
//  ID_VAL      0     constant ID driven on AWID/ARID; B/R IDs are checked against it
//  LINE_BEATS  4     beats per line transfer; power of 2, 1..16
//  TIMEOUT     1023  max cycles without a handshake before abort; 0 disables the watchdog
// PORTS
//  clk        in   1         clock
//  rst        in   1         synchronous reset, active-low
//  req_valid  in   1         request strobe
//  req_ready  out  1         request accepted when req_valid&req_ready
//  req_write  in   1         1=write, 0=read
//  req_line   in   1         1=LINE_BEATS burst, 0=single beat
//  req_addr   in   ADDR_W    byte address
//  req_wstrb  in   DATA_W/8  byte strobes (single write only)
//  wd_valid   in   1         write-data stream valid
//  wd_data    in   DATA_W    write-data beat
//  wd_ready   out  1         write beat consumed
//  rd_valid   out  1         read beat valid (1 cycle per beat)
//  rd_data    out  DATA_W    read beat
//  rd_last    out  1         last read beat of transaction
//  done       out  1         1-cycle completion pulse
//  err        out  1         valid with done: transaction failed
//  AW*/W*/B*/AR*/R*  AXI4 master channels, DATA_W/ADDR_W/ID_W wide, LEN 4b, SIZE 3b, BURST 2b
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; all VALID/READY AXI outputs, wd_ready, rd_valid, rd_last, done, err = 0.
//  Counters are cleared. Reset mid-transaction abandons it without done.
//  FSM: IDLE -> AR -> R -> IDLE; IDLE -> AW -> W -> B -> IDLE.
//  req_ready=1 only in IDLE. Request fields are registered at acceptance; inputs are ignored afterwards.
//  Address: line -> req_addr with low log2(LINE_BEATS*DATA_W/8) bits zeroed; single -> unchanged.
//  LEN: line=LINE_BEATS-1, single=0; SIZE=log2(DATA_W/8); BURST=INCR (2'b01).
//  AR/AW: VALID is asserted the cycle after acceptance and held with stable payload until READY.
//  R: RREADY=1 throughout R.
//    - Each RVALID beat -> rd_valid/rd_data registered, 1-cycle latency.
//    - Beat counter increments per beat. rd_last is set on beat LEN.
//    - Transaction ends on beat LEN: done=1 in the same cycle as rd_last.
//    - err is sticky per transaction, set by: RRESP!=OKAY, RID!=ID_VAL, RLAST on beat<LEN, or RLAST=0 on beat LEN.
//  W (entered after AW handshake):
//    - WVALID=wd_valid, WDATA=wd_data, wd_ready=WREADY (combinational, W state only).
//    - WLAST=1 on beat LEN. WSTRB=req_wstrb for single, all-ones for line.
//  B: BREADY=1. On BVALID: done=1, err=(BRESP!=OKAY)|(BID!=ID_VAL)|sticky.
//  Watchdog:
//    - Counter clears on entry to a non-IDLE state and on every AR/AW/W/R/B handshake; increments otherwise.
//    - Counter==TIMEOUT -> all VALID/READY low, IDLE next cycle, done=1, err=1.
//  done/err are held 0 except on the completion cycle. Back-to-back: a new request may be accepted the cycle after done.
// TESTING
//  Reset: rst=0 for 2 cycles mid-burst -> state IDLE, all VALIDs 0, no done pulse.
//  Line read: LINE_BEATS=4, addr 0x1234 -> ARADDR=0x1230, ARLEN=3.
//    - Beats A0..A3 with RLAST on beat 3 -> 4 rd_valid; rd_last+done on the 4th; err=0.
//  Single write: addr 0x8, wstrb=4'b0011 -> AWLEN=0, WSTRB=0011, WLAST=1.
//    - BRESP=SLVERR -> done=1, err=1.
//  Protocol errors: RLAST on beat 1 of a 4-beat burst -> err=1 at done.
//    - ARREADY stalled 50 cycles -> ARVALID/ARADDR stable throughout.
//  Watchdog: TIMEOUT=16, AWREADY held 0 -> abort after 16 stall cycles, done=1, err=1, back in IDLE.
//  Stream backpressure: line write with wd_valid toggling every cycle -> exactly 4 W beats, WLAST only on beat 3.

Source files
------------

// File: rtl/axi_burst_master_if.sv
// axi_burst_master_if: AXI4 address/data/response channels between an L1 cache master and the bus
interface axi_burst_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid, awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast, wvalid, wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid, bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid, arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast, rvalid, rready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );
  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// axi_burst_master: L1 cache AXI4 master doing single-word or INCR line reads/writes with response checks and watchdog
module axi_burst_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int ID_VAL     = 0,
  parameter int LINE_BEATS = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic                req_line,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic                wd_valid,
  input  logic [DATA_W-1:0]   wd_data,
  output logic                wd_ready,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                done,
  output logic                err,
  axi_burst_master_if.master  axi
);
  localparam int SW = DATA_W / 8;
  localparam int OFF = $clog2(LINE_BEATS * SW);
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [ID_W-1:0] ID = ID_W'(ID_VAL);
  localparam logic [3:0] LINE_LEN = 4'(LINE_BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFF) - 1);
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;
  state_t            state;
  logic              line_q, sticky, to;
  logic [ADDR_W-1:0] addr_q;
  logic [SW-1:0]     wstrb_q;
  logic [3:0]        beat, len;
  logic [CW-1:0]     cnt;
  logic              ar_hs, aw_hs, w_hs, r_hs, b_hs, hs, r_bad, b_bad;
  assign len = line_q ? LINE_LEN : 4'd0;
  assign to = TIMEOUT != 0 && state != IDLE && cnt == CW'(TIMEOUT);
  assign req_ready = state == IDLE;
  assign axi.arvalid = state == AR && !to;
  assign axi.awvalid = state == AW && !to;
  assign axi.rready = state == R && !to;
  assign axi.bready = state == B && !to;
  assign axi.wvalid = state == W && !to && wd_valid;
  assign wd_ready = state == W && !to && axi.wready;
  assign axi.araddr = addr_q;
  assign axi.awaddr = addr_q;
  assign axi.arlen = len;
  assign axi.awlen = len;
  assign axi.arsize = 3'($clog2(SW));
  assign axi.awsize = 3'($clog2(SW));
  assign axi.arburst = 2'b01;
  assign axi.awburst = 2'b01;
  assign axi.arid = ID;
  assign axi.awid = ID;
  assign axi.wdata = wd_data;
  assign axi.wstrb = line_q ? '1 : wstrb_q;
  assign axi.wlast = beat == len;
  assign ar_hs = axi.arvalid && axi.arready;
  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs = axi.wvalid && axi.wready;
  assign r_hs = axi.rvalid && axi.rready;
  assign b_hs = axi.bvalid && axi.bready;
  assign hs = ar_hs || aw_hs || w_hs || r_hs || b_hs;
  // RLAST must coincide exactly with the beat numbered LEN
  assign r_bad = axi.rresp != 2'b00 || axi.rid != ID || axi.rlast != (beat == len);
  assign b_bad = axi.bresp != 2'b00 || axi.bid != ID;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      line_q <= 1'b0;
      addr_q <= '0;
      wstrb_q <= '0;
      beat <= '0;
      sticky <= 1'b0;
      cnt <= '0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      rd_last <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      cnt <= (hs || TIMEOUT == 0) ? '0 : cnt + 1'b1;
      if (to) begin
        state <= IDLE;
        done <= 1'b1;
        err <= 1'b1;
      end else begin
        case (state)
          IDLE: if (req_valid) begin
            state <= req_write ? AW : AR;
            line_q <= req_line;
            addr_q <= req_line ? req_addr & LINE_MASK : req_addr;
            wstrb_q <= req_wstrb;
            beat <= '0;
            sticky <= 1'b0;
            cnt <= '0;
          end
          AR: if (ar_hs) state <= R;
          R: if (r_hs) begin
            rd_valid <= 1'b1;
            rd_data <= axi.rdata;
            beat <= beat + 1'b1;
            sticky <= sticky | r_bad;
            if (beat == len) begin
              rd_last <= 1'b1;
              done <= 1'b1;
              err <= sticky | r_bad;
              state <= IDLE;
            end
          end
          AW: if (aw_hs) state <= W;
          W: if (w_hs) begin
            beat <= beat + 1'b1;
            if (beat == len) state <= B;
          end
          B: if (b_hs) begin
            done <= 1'b1;
            err <= sticky | b_bad;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: directed checks of line/single reads and writes, protocol errors, reset and watchdog
module tb_axi_burst_master;
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 0, req_valid2 = 0, req_write = 0, req_line = 0;
  logic [31:0] req_addr = '0;
  logic [3:0] req_wstrb = '0;
  logic wd_valid = 0;
  logic [31:0] wd_data = '0;
  logic req_ready, wd_ready, rd_valid, rd_last, done, err;
  logic [31:0] rd_data;
  logic req_ready2, wd_ready2, rd_valid2, rd_last2, done2, err2;
  logic [31:0] rd_data2;
  int n_tests = 0, n_fail = 0;
  axi_burst_master_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi ();
  axi_burst_master_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi2 ();
  axi_burst_master #(.TIMEOUT(1023)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_line(req_line), .req_addr(req_addr), .req_wstrb(req_wstrb), .wd_valid(wd_valid),
    .wd_data(wd_data), .wd_ready(wd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .done(done), .err(err), .axi(axi));
  axi_burst_master #(.TIMEOUT(16)) dut_wd (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write),
    .req_line(req_line), .req_addr(req_addr), .req_wstrb(req_wstrb), .wd_valid(wd_valid),
    .wd_data(wd_data), .wd_ready(wd_ready2), .rd_valid(rd_valid2), .rd_data(rd_data2),
    .rd_last(rd_last2), .done(done2), .err(err2), .axi(axi2));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    int bad, beats, wlast_bad;
    logic [3:0] strb0;
    {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid, axi.rlast} = '0;
    {axi.bid, axi.bresp, axi.rid, axi.rresp, axi.rdata} = '0;
    {axi2.awready, axi2.wready, axi2.bvalid, axi2.arready, axi2.rvalid, axi2.rlast} = '0;
    {axi2.bid, axi2.bresp, axi2.rid, axi2.rresp, axi2.rdata} = '0;
    cyc();
    cyc();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 0);
    chk("rst_outs", {wd_ready, rd_valid, rd_last, done, err}, 0);
    rst = 1;
    // line read, address aligned down to the 16-byte line
    req_valid = 1; req_line = 1; req_write = 0; req_addr = 32'h1234;
    cyc();
    req_valid = 0; req_addr = 32'hFFFF_FFFF;
    #1;
    chk("lr_req_ready", req_ready, 0);
    chk("lr_arvalid", axi.arvalid, 1);
    chk("lr_araddr", axi.araddr, 32'h1230);
    chk("lr_arlen", axi.arlen, 3);
    chk("lr_arsize_burst", {axi.arsize, axi.arburst}, {3'd2, 2'b01});
    axi.arready = 1;
    cyc();
    axi.arready = 0;
    #1;
    chk("lr_ar_drop", {axi.arvalid, axi.rready}, 2'b01);
    for (int i = 0; i < 4; i++) begin
      axi.rvalid = 1; axi.rdata = 32'hA0 + i; axi.rlast = (i == 3);
      cyc();
      chk("lr_rd_valid", rd_valid, 1);
      chk("lr_rd_data", rd_data, 32'hA0 + i);
      chk("lr_last_done", {rd_last, done, err}, (i == 3) ? 3'b110 : 3'b000);
    end
    axi.rvalid = 0; axi.rlast = 0;
    cyc();
    chk("lr_after", {done, rd_valid, req_ready}, 3'b001);
    // single write with SLVERR response
    req_valid = 1; req_write = 1; req_line = 0; req_addr = 32'h8; req_wstrb = 4'b0011;
    cyc();
    req_valid = 0; req_wstrb = 4'hF;
    #1;
    chk("sw_awvalid", axi.awvalid, 1);
    chk("sw_awaddr", axi.awaddr, 32'h8);
    chk("sw_awlen", axi.awlen, 0);
    axi.awready = 1;
    cyc();
    axi.awready = 0; wd_valid = 1; wd_data = 32'hDEAD_BEEF; axi.wready = 1;
    #1;
    chk("sw_w", {axi.wvalid, axi.wlast, wd_ready, axi.wstrb}, {3'b111, 4'b0011});
    chk("sw_wdata", axi.wdata, 32'hDEAD_BEEF);
    cyc();
    wd_valid = 0; axi.wready = 0;
    #1;
    chk("sw_b", {axi.bready, axi.wvalid, done}, 3'b100);
    axi.bvalid = 1; axi.bresp = 2'b10;
    cyc();
    axi.bvalid = 0; axi.bresp = 2'b00;
    chk("sw_done_err", {done, err}, 2'b11);
    cyc();
    chk("sw_done_clear", {done, err, req_ready}, 3'b001);
    // ARREADY stall then early RLAST
    req_valid = 1; req_write = 0; req_line = 1; req_addr = 32'h2048;
    cyc();
    req_valid = 0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h2040 || axi.arlen !== 4'd3) bad++;
      cyc();
    end
    chk("stall_ar_unstable_cycles", bad, 0);
    axi.arready = 1;
    cyc();
    axi.arready = 0;
    for (int i = 0; i < 4; i++) begin
      axi.rvalid = 1; axi.rdata = 32'hB0 + i; axi.rlast = (i == 1);
      cyc();
      chk("el_rd_data", rd_data, 32'hB0 + i);
      chk("el_done_err", {rd_last, done, err}, (i == 3) ? 3'b111 : 3'b000);
    end
    axi.rvalid = 0; axi.rlast = 0;
    cyc();
    // line write with wd_valid toggling
    req_valid = 1; req_write = 1; req_line = 1; req_addr = 32'h105; req_wstrb = 4'b0001;
    cyc();
    req_valid = 0;
    chk("lw_awaddr", axi.awaddr, 32'h100);
    chk("lw_awlen", axi.awlen, 3);
    axi.awready = 1;
    cyc();
    axi.awready = 0; axi.wready = 1;
    beats = 0; wlast_bad = 0; strb0 = '0;
    for (int k = 0; k < 12; k++) begin
      wd_valid = (k % 2 == 0); wd_data = 32'hC0 + k;
      #1;
      if (axi.wvalid && axi.wready) begin
        beats++;
        if (beats == 1) strb0 = axi.wstrb;
        if (axi.wlast !== (beats == 4)) wlast_bad++;
      end
      cyc();
    end
    wd_valid = 0; axi.wready = 0;
    chk("lw_beats", beats, 4);
    chk("lw_wlast_misplaced", wlast_bad, 0);
    chk("lw_wstrb", strb0, 4'hF);
    axi.bvalid = 1;
    cyc();
    axi.bvalid = 0;
    chk("lw_done_err", {done, err}, 2'b10);
    // reset in the middle of a read burst
    req_valid = 1; req_write = 0; req_line = 1; req_addr = 32'h0;
    cyc();
    req_valid = 0; axi.arready = 1;
    cyc();
    axi.arready = 0; axi.rvalid = 1; axi.rdata = 32'h55;
    cyc();
    axi.rvalid = 0;
    rst = 0;
    cyc();
    chk("mr_done_1", done, 0);
    cyc();
    chk("mr_done_2", done, 0);
    chk("mr_idle", {req_ready, axi.arvalid, axi.rready, axi.awvalid, rd_valid}, 5'b10000);
    rst = 1;
    cyc();
    chk("mr_after", {done, req_ready}, 2'b01);
    // watchdog on the TIMEOUT=16 instance, AWREADY never asserted
    req_valid2 = 1; req_write = 1; req_line = 0; req_addr = 32'h10;
    cyc();
    req_valid2 = 0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (axi2.awvalid !== 1'b1 || done2 !== 1'b0) bad++;
      cyc();
    end
    chk("wd_stall_cycles", bad, 0);
    chk("wd_abort_cycle", {axi2.awvalid, done2}, 2'b00);
    cyc();
    chk("wd_done_err", {done2, err2, req_ready2}, 3'b111);
    cyc();
    chk("wd_after", {done2, err2, axi2.awvalid}, 3'b000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
